// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Header byte layout and payload counter width live here.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        HDR,
        PAY
    } state_t;

    localparam logic [3:0] HDR_MAGIC = 4'hA;
    localparam int         LEN_W     = 12;

    function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
        return {HDR_MAGIC, idx};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after `last`,
// wrapping modulo N_REQ.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [3:0]       last,
    output logic [3:0]       gnt_idx,
    output logic             found
);

    logic [15:0] req_w;
    logic [3:0]  idx;

    always_comb begin
        req_w   = 16'(req);
        idx     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = 4'((int'(last) + k) % N_REQ);
            if (!found && req_w[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one buffered UART transmitter
// among N_REQ byte streams, with an optional source header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 256,
    parameter bit HDR_EN  = 1'b1
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               fifo_afull,
    output logic               dat_en,
    output logic [7:0]         dat,
    output logic [N_REQ-1:0]   grant,
    output logic               busy
);

    localparam logic [LEN_W-1:0] LEN_END = LEN_W'(MAX_LEN - 1);

    state_t           state;
    state_t           state_nx;
    logic [3:0]       owner;
    logic [3:0]       last_owner;
    logic [3:0]       pick_idx;
    logic             pick_found;
    logic [15:0]      pick_oh;
    logic [LEN_W-1:0] cnt;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;
    logic             hdr_send;
    logic             accept;
    logic             pay_done;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req     (req_valid),
        .last    (last_owner),
        .gnt_idx (pick_idx),
        .found   (pick_found)
    );

    assign pick_oh = 16'(1) << pick_idx;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == 4'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (|req_valid) state_nx = ARB;
            ARB: begin
                if (!pick_found)
                    state_nx = IDLE;
                else if (HDR_EN)
                    state_nx = HDR;
                else
                    state_nx = PAY;
            end
            HDR:  if (!fifo_afull) state_nx = PAY;
            PAY:  if (pay_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // grant is the registered one-hot of owner, so it doubles as the ready mask
    always_comb begin
        busy      = (state != IDLE);
        hdr_send  = (state == HDR) && !fifo_afull;
        accept    = (state == PAY) && sel_valid && !fifo_afull;
        pay_done  = accept && (sel_last || (cnt == LEN_END));
        req_ready = ((state == PAY) && !fifo_afull) ? grant : '0;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            owner      <= '0;
            last_owner <= 4'(N_REQ - 1);
            grant      <= '0;
            cnt        <= '0;
            dat_en     <= 1'b0;
            dat        <= 8'h00;
        end else begin
            dat_en <= hdr_send || accept;
            if (hdr_send)
                dat <= hdr_byte(owner);
            else if (accept)
                dat <= sel_data;
            if ((state == ARB) && pick_found) begin
                owner <= pick_idx;
                grant <= pick_oh[N_REQ-1:0];
                cnt   <= '0;
            end
            if (accept)
                cnt <= cnt + 1'b1;
            if (pay_done) begin
                grant      <= '0;
                last_owner <= owner;
            end
        end
    end

endmodule
